// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Op enum, base opcodes and the S1 request bundle.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_LUI   = 4'd0,
    OP_AUIPC = 4'd1,
    OP_JAL   = 4'd2,
    OP_JALR  = 4'd3,
    OP_BEQ   = 4'd4,
    OP_BNE   = 4'd5,
    OP_LW    = 4'd6,
    OP_SW    = 4'd7,
    OP_ADDI  = 4'd8,
    OP_ANDI  = 4'd9,
    OP_ORI   = 4'd10,
    OP_SLTI  = 4'd11,
    OP_SLTIU = 4'd12,
    OP_SLLI  = 4'd13,
    OP_SRAI  = 4'd14,
    OP_RSVD  = 4'd15
  } enc_op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    enc_op_t     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
  } s1_t;

  function automatic logic [2:0] func3(enc_op_t op);
    logic [2:0] f;
    f = 3'b000;
    unique case (op)
      OP_BNE:   f = 3'b001;
      OP_LW:    f = 3'b010;
      OP_SW:    f = 3'b010;
      OP_ANDI:  f = 3'b111;
      OP_ORI:   f = 3'b110;
      OP_SLTI:  f = 3'b010;
      OP_SLTIU: f = 3'b011;
      OP_SLLI:  f = 3'b001;
      OP_SRAI:  f = 3'b101;
      default:  f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_range_chk.sv
// Immediate legality check for one encoder request.
// Ranges are in the units the immediate decoder produces.
module imm_range_chk
  import instr_encoder_pkg::*;
(
  input  enc_op_t     op_i,
  input  logic [31:0] imm_i,
  output logic        legal_o
);

  logic s12_ok;
  logic j20_ok;
  logic u12_ok;
  logic z12_ok;
  logic sh5_ok;

  assign s12_ok = (&imm_i[31:11]) | (~|imm_i[31:11]);
  assign j20_ok = (&imm_i[31:19]) | (~|imm_i[31:19]);
  assign u12_ok = ~|imm_i[11:0];
  assign z12_ok = ~|imm_i[31:12];
  assign sh5_ok = ~|imm_i[31:5];

  always_comb begin
    legal_o = s12_ok;
    unique case (op_i)
      OP_LUI,
      OP_AUIPC: legal_o = u12_ok;
      OP_JAL:   legal_o = j20_ok;
      OP_SLTIU: legal_o = z12_ok;
      OP_SLLI,
      OP_SRAI:  legal_o = sh5_ok;
      OP_RSVD:  legal_o = 1'b0;
      default:  legal_o = s12_ok;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I encoder: S1 registers and range-checks,
// S2 holds the encoded word with its address and error flag.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned            ADDR_W     = 32,
  parameter int unsigned            ERR_CNT_W  = 8,
  parameter logic [ADDR_W-1:0]      RESET_ADDR = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [3:0]           op_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [31:0]          imm_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [31:0]          instr_o,
  output logic [ADDR_W-1:0]    instr_addr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 load_i,
  input  logic [ADDR_W-1:0]    base_i
);

  logic        s1_v;
  s1_t         s1;
  logic        s2_v;
  logic        adv1;
  logic        adv2;
  logic        hs;
  logic        req_legal;
  logic [31:0] enc;
  logic [2:0]  f3;

  assign adv2        = !s2_v | instr_ready_i;
  assign adv1        = !s1_v | adv2;
  assign req_ready_o = adv1;
  assign hs          = s2_v & instr_ready_i;

  assign instr_valid_o = s2_v;

  imm_range_chk u_chk (
    .op_i    (enc_op_t'(op_i)),
    .imm_i   (imm_i),
    .legal_o (req_legal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v <= 1'b0;
      s1   <= '0;
    end else if (adv1) begin
      s1_v <= req_valid_i;
      if (req_valid_i) begin
        s1.op    <= enc_op_t'(op_i);
        s1.rd    <= rd_i;
        s1.rs1   <= rs1_i;
        s1.rs2   <= rs2_i;
        s1.imm   <= imm_i;
        s1.legal <= req_legal;
      end
    end
  end

  assign f3 = func3(s1.op);

  always_comb begin
    enc = NOP_INSTR;
    unique case (s1.op)
      OP_LUI:
        enc = {s1.imm[31:12], s1.rd, OPC_LUI};
      OP_AUIPC:
        enc = {s1.imm[31:12], s1.rd, OPC_AUIPC};
      OP_JAL:
        enc = {s1.imm[19], s1.imm[9:0], s1.imm[10],
               s1.imm[18:11], s1.rd, OPC_JAL};
      OP_JALR:
        enc = {s1.imm[11:0], s1.rs1, f3, s1.rd, OPC_JALR};
      OP_BEQ,
      OP_BNE:
        enc = {s1.imm[11], s1.imm[9:4], s1.rs2, s1.rs1,
               f3, s1.imm[3:0], s1.imm[10], OPC_BRANCH};
      OP_LW:
        enc = {s1.imm[11:0], s1.rs1, f3, s1.rd, OPC_LOAD};
      OP_SW:
        enc = {s1.imm[11:5], s1.rs2, s1.rs1, f3,
               s1.imm[4:0], OPC_STORE};
      OP_ADDI,
      OP_ANDI,
      OP_ORI,
      OP_SLTI,
      OP_SLTIU:
        enc = {s1.imm[11:0], s1.rs1, f3, s1.rd, OPC_OPIMM};
      OP_SLLI:
        enc = {7'b0000000, s1.imm[4:0], s1.rs1, f3,
               s1.rd, OPC_OPIMM};
      OP_SRAI:
        enc = {7'b0100000, s1.imm[4:0], s1.rs1, f3,
               s1.rd, OPC_OPIMM};
      OP_RSVD:
        enc = NOP_INSTR;
    endcase
    if (!s1.legal) enc = NOP_INSTR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_v    <= 1'b0;
      instr_o <= '0;
      err_o   <= 1'b0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        instr_o <= enc;
        err_o   <= !s1.legal;
      end
    end
  end

  // A load overrides the post-handshake increment in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_addr_o <= RESET_ADDR;
    end else if (load_i) begin
      instr_addr_o <= base_i;
    end else if (hs) begin
      instr_addr_o <= instr_addr_o + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (hs && err_o && !(&err_cnt_o)) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push
// expected words, a monitor pops on each output handshake.
module tb_instr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  op_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;
  logic        load_i;
  logic [31:0] base_i;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] addr;
    logic [3:0]  op;
    logic [31:0] imm;
    bit          rt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;

  instr_encoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .op_i          (op_i),
    .rd_i          (rd_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .imm_i         (imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_addr_o  (instr_addr_o),
    .err_o         (err_o),
    .err_cnt_o     (err_cnt_o),
    .load_i        (load_i),
    .base_i        (base_i)
  );

  always #5 clk_i = ~clk_i;

  // Independent immediate decoder, used for the round-trip check.
  function automatic logic [31:0] imm_dec(logic [3:0] op, logic [31:0] i);
    case (op)
      4'd0, 4'd1: return {i[31:12], 12'b0};
      4'd2:       return {{12{i[31]}}, i[31], i[19:12], i[20], i[30:21]};
      4'd4, 4'd5: return {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
      4'd7:       return {{20{i[31]}}, i[31:25], i[11:7]};
      4'd12:      return {20'b0, i[31:20]};
      4'd13, 4'd14: return {27'b0, i[24:20]};
      default:    return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] ei,
                      input logic ee, input logic [31:0] ea,
                      input bit push);
    exp_t e;
    bit acc;
    acc = 1'b0;
    op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    req_valid_i = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        acc = 1'b1;
        if (push) begin
          e.instr = ei; e.err = ee; e.addr = ea;
          e.op = op; e.imm = imm; e.rt = !ee;
          q.push_back(e);
        end
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d never accepted", op);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk_i);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words pending, 0 expected", q.size());
    end
  endtask

  always @(negedge clk_i) begin
    if (run && !rst_i && instr_valid_o && instr_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h, none expected", instr_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("instr", instr_o, e.instr);
        chk("err", 32'(err_o), 32'(e.err));
        chk("addr", instr_addr_o, e.addr);
        if (e.rt) chk("roundtrip", imm_dec(e.op, instr_o), e.imm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; instr_ready_i = 1'b1;
    op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    load_i = 1'b0; base_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    run = 1'b1;

    // Latency: valid appears two cycles after the accepting cycle.
    send(4'd8, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 32'h0, 1);
    chk("lat_early", 32'(instr_valid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("lat_valid", 32'(instr_valid_o), 32'd1);
    drain();

    send(4'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 32'h4, 1);
    send(4'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1, 32'h8, 1);
    drain();
    chk("errcnt_lui", 32'(err_cnt_o), 32'd1);

    send(4'd7, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0, 32'hC, 1);
    send(4'd2, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_F0EF, 1'b0, 32'h10, 1);
    send(4'd4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFE, 32'hFE20_8EE3, 1'b0, 32'h14, 1);
    send(4'd14, 5'd3, 5'd4, 5'd0, 32'd7, 32'h4072_5193, 1'b0, 32'h18, 1);
    send(4'd13, 5'd3, 5'd4, 5'd0, 32'd32, 32'h0000_0013, 1'b1, 32'h1C, 1);
    send(4'd8, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 1'b1, 32'h20, 1);
    send(4'd12, 5'd1, 5'd2, 5'd0, 32'd4095, 32'hFFF1_3093, 1'b0, 32'h24, 1);
    send(4'd2, 5'd1, 5'd0, 5'd0, 32'd524288, 32'h0000_0013, 1'b1, 32'h28, 1);
    drain();
    chk("errcnt_mix", 32'(err_cnt_o), 32'd4);

    // Backpressure with a freshly loaded base.
    load_i = 1'b1; base_i = 32'h100;
    @(posedge clk_i); #1;
    load_i = 1'b0;
    instr_ready_i = 1'b0;
    send(4'd8, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0, 32'h100, 1);
    send(4'd8, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0, 32'h104, 1);
    chk("bp_ready_low", 32'(req_ready_o), 32'd0);
    chk("bp_hold_instr", instr_o, 32'h0010_0093);
    chk("bp_hold_addr", instr_addr_o, 32'h100);
    fork
      send(4'd8, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0, 32'h108, 1);
      begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("bp_still_held", instr_o, 32'h0010_0093);
        instr_ready_i = 1'b1;
      end
    join
    drain();

    // Load coinciding with an output handshake.
    send(4'd8, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0, 32'h10C, 1);
    @(posedge clk_i); #1;
    chk("ld_hs_valid", 32'(instr_valid_o), 32'd1);
    load_i = 1'b1; base_i = 32'h200;
    @(posedge clk_i); #1;
    load_i = 1'b0;
    send(4'd8, 5'd5, 5'd0, 5'd0, 32'd5, 32'h0050_0293, 1'b0, 32'h200, 1);
    drain();

    // Reset while stalled drops both in-flight words.
    instr_ready_i = 1'b0;
    send(4'd8, 5'd6, 5'd0, 5'd0, 32'd6, 32'h0, 1'b0, 32'h0, 0);
    send(4'd15, 5'd7, 5'd0, 5'd0, 32'd7, 32'h0, 1'b0, 32'h0, 0);
    chk("pre_rst_valid", 32'(instr_valid_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("mid_rst_addr", instr_addr_o, 32'd0);
    chk("mid_rst_errcnt", 32'(err_cnt_o), 32'd0);
    rst_i = 1'b0;
    instr_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("post_rst_valid", 32'(instr_valid_o), 32'd0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++)
      send(4'd15, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0000_0013, 1'b1, 32'(i * 4), 1);
    drain();
    chk("errcnt_sat", 32'(err_cnt_o), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
